layer_norm_row_streamer: RTL

Row-streaming front/back end for `layer_norm_top`. It accepts x elements one per beat over a valid/ready stream and packs D_MODEL of them into the flat row vector. It then pulses `ln_start`, waits for `ln_done`, captures the flat y vector and serialises it out one element per beat over a second valid/ready stream. It also holds the gamma/beta parameter vectors, loaded through a word-write port, and tracks row position within a NUM_ROWS-row matrix.

---
 rtl/layer_norm_row_streamer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/layer_norm_row_streamer.sv
// Row streamer around layer_norm_top: packs a D_MODEL-element input stream into a row, runs one
// normalisation, then serialises the result. Define LN_STREAM_PINGPONG_EN for double input buffering.
module layer_norm_row_streamer #(
    parameter int unsigned D_MODEL     = 128,
    parameter int unsigned X_WIDTH     = 16,
    parameter int unsigned Y_WIDTH     = 16,
    parameter int unsigned PARAM_WIDTH = 8,
    parameter int unsigned NUM_ROWS    = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [X_WIDTH-1:0]             s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [Y_WIDTH-1:0]             m_data,
    output logic                           m_last,
    output logic                           m_frame_last,
    input  logic                           prm_we,
    input  logic                           prm_sel,
    input  logic [$clog2(D_MODEL)-1:0]     prm_addr,
    input  logic [PARAM_WIDTH-1:0]         prm_data,
    output logic                           ln_start,
    output logic [D_MODEL*X_WIDTH-1:0]     ln_x_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0] ln_gamma_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0] ln_beta_flat,
    input  logic                           ln_done,
    input  logic [D_MODEL*Y_WIDTH-1:0]     ln_y_flat
);
    localparam int unsigned AW = $clog2(D_MODEL);
    localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {StIdle, StFill, StStart, StWait, StDrain} state_e;

    state_e                         state_q, state_d;
    logic [AW-1:0]                  elem_q, elem_d;
    logic [AW-1:0]                  out_idx_q, out_idx_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [D_MODEL*Y_WIDTH-1:0]     y_buf_q, y_buf_d;
    logic [D_MODEL*PARAM_WIDTH-1:0] gamma_q, gamma_d, beta_q, beta_d;
    logic                           s_fire, m_fire, drain_done, row_ready;

    assign s_fire     = s_valid && s_ready;
    assign m_fire     = m_valid && m_ready;
    assign drain_done = m_fire && (out_idx_q == AW'(D_MODEL - 1));

`ifdef LN_STREAM_PINGPONG_EN
    logic [1:0][D_MODEL*X_WIDTH-1:0] x_buf_q, x_buf_d;
    logic [1:0]                      full_q, full_d;
    logic                            wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;

    // Filling continues into the alternate buffer whenever it is free.
    assign s_ready   = (state_q != StIdle) && !full_q[wr_sel_q];
    assign ln_x_flat = x_buf_q[rd_sel_q];
    assign row_ready = full_d[rd_sel_d];

    always_comb begin
        x_buf_d  = x_buf_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (s_fire) begin
            x_buf_d[wr_sel_q][elem_q*X_WIDTH +: X_WIDTH] = s_data;
            if (elem_q == AW'(D_MODEL - 1)) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end
        if (drain_done) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end
`else
    logic [D_MODEL*X_WIDTH-1:0] x_buf_q, x_buf_d;

    assign s_ready   = (state_q == StFill);
    assign ln_x_flat = x_buf_q;
    assign row_ready = s_fire && (elem_q == AW'(D_MODEL - 1));

    always_comb begin
        x_buf_d = x_buf_q;
        if (s_fire) begin
            x_buf_d[elem_q*X_WIDTH +: X_WIDTH] = s_data;
        end
    end
`endif

    always_comb begin
        elem_d    = s_fire ? elem_q + 1'b1 : elem_q;
        out_idx_d = m_fire ? out_idx_q + 1'b1 : out_idx_q;
        y_buf_d   = (state_q == StWait && ln_done) ? ln_y_flat : y_buf_q;
        row_d     = row_q;
        if (drain_done) begin
            row_d = (row_q == RW'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
        end
        gamma_d = gamma_q;
        beta_d  = beta_q;
        if (prm_we) begin
            if (prm_sel) beta_d[prm_addr*PARAM_WIDTH +: PARAM_WIDTH] = prm_data;
            else         gamma_d[prm_addr*PARAM_WIDTH +: PARAM_WIDTH] = prm_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            elem_q    <= '0;
            out_idx_q <= '0;
            row_q     <= '0;
            y_buf_q   <= '0;
            gamma_q   <= '0;
            beta_q    <= '0;
            x_buf_q   <= '0;
`ifdef LN_STREAM_PINGPONG_EN
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            out_idx_q <= out_idx_d;
            row_q     <= row_d;
            y_buf_q   <= y_buf_d;
            gamma_q   <= gamma_d;
            beta_q    <= beta_d;
            x_buf_q   <= x_buf_d;
`ifdef LN_STREAM_PINGPONG_EN
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFill;
            StFill:  if (row_ready) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (ln_done) state_d = StDrain;
            StDrain: if (drain_done) state_d = row_ready ? StStart : StFill;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ln_start      = (state_q == StStart);
        m_valid       = (state_q == StDrain);
        m_data        = m_valid ? y_buf_q[out_idx_q*Y_WIDTH +: Y_WIDTH] : '0;
        m_last        = m_valid && (out_idx_q == AW'(D_MODEL - 1));
        m_frame_last  = m_last && (row_q == RW'(NUM_ROWS - 1));
        ln_gamma_flat = gamma_q;
        ln_beta_flat  = beta_q;
    end
endmodule
